irq_controller: RTL

//  Interrupt source side of the CPU interrupt interface. Synchronises the raw IO

---
 rtl/irq_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Interrupt source front-end: synchronises raw IO lines, latches rising edges as pending,
// and presents one prioritised, maskable request with its entry vector to the CPU.
module irq_controller #(
    parameter logic [31:0] ENTRY2 = 32'h0000_0400,
    parameter logic [31:0] ENTRY1 = 32'h0000_0600,
    parameter logic [31:0] ENTRY0 = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  mask,
    input  logic        int_disable,
    input  logic        irq_ack,
    input  logic        eret,
    output logic        irq_req,
    output logic [1:0]  irq_id,
    output logic [31:0] irq_entry,
    output logic [2:0]  pending,
    output logic [2:0]  in_service
);

    typedef enum logic [1:0] {StIdle, StReq, StAckd} state_e;

    state_e      state_q, state_d;
    logic [2:0]  sync1_q, sync2_q, prev_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  in_service_q, in_service_d;
    logic        irq_req_q, irq_req_d;
    logic [1:0]  irq_id_q, irq_id_d;
    logic [31:0] irq_entry_q, irq_entry_d;

    logic [2:0]  edge_det;
    logic [2:0]  allow;
    logic [2:0]  eligible;
    logic        any_eligible;
    logic [1:0]  best_id;
    logic        ack_take;
    logic [2:0]  ack_bit;
    logic [2:0]  eret_clr;

    function automatic logic [31:0] entry_of(logic [1:0] id);
        unique case (id)
            2'd2:    entry_of = ENTRY2;
            2'd1:    entry_of = ENTRY1;
            default: entry_of = ENTRY0;
        endcase
    endfunction

    assign edge_det = sync2_q & ~prev_q;

    // Only sources strictly above the highest in-service source may preempt.
    always_comb begin
        allow = 3'b111;
        if (in_service_q[2]) begin
            allow = 3'b000;
        end else if (in_service_q[1]) begin
            allow = 3'b100;
        end else if (in_service_q[0]) begin
            allow = 3'b110;
        end
    end

    assign eligible     = pending_q & mask & {3{~int_disable}} & allow;
    assign any_eligible = |eligible;

    always_comb begin
        best_id = 2'd0;
        if (eligible[2]) begin
            best_id = 2'd2;
        end else if (eligible[1]) begin
            best_id = 2'd1;
        end
    end

    assign ack_take = (state_q == StReq) && irq_ack;
    assign ack_bit  = 3'b001 << irq_id_q;

    always_comb begin
        eret_clr = 3'b000;
        if (eret) begin
            if (in_service_q[2]) begin
                eret_clr = 3'b100;
            end else if (in_service_q[1]) begin
                eret_clr = 3'b010;
            end else if (in_service_q[0]) begin
                eret_clr = 3'b001;
            end
        end
    end

    // A fresh edge on the acknowledged source wins over the ack clear.
    assign pending_d    = (pending_q & ~(ack_take ? ack_bit : 3'b000)) | edge_det;
    assign in_service_d = (in_service_q & ~eret_clr) | (ack_take ? ack_bit : 3'b000);

    always_comb begin
        state_d     = state_q;
        irq_req_d   = irq_req_q;
        irq_id_d    = irq_id_q;
        irq_entry_d = irq_entry_q;
        unique case (state_q)
            StIdle: begin
                if (any_eligible) begin
                    state_d     = StReq;
                    irq_req_d   = 1'b1;
                    irq_id_d    = best_id;
                    irq_entry_d = entry_of(best_id);
                end
            end
            StReq: begin
                if (irq_ack) begin
                    state_d   = StAckd;
                    irq_req_d = 1'b0;
                end else if (any_eligible) begin
                    irq_id_d    = best_id;
                    irq_entry_d = entry_of(best_id);
                end else begin
                    state_d   = StIdle;
                    irq_req_d = 1'b0;
                end
            end
            StAckd: begin
                // One blanking cycle lets the CPU's int_disable write land first.
                state_d   = StIdle;
                irq_req_d = 1'b0;
            end
            default: begin
                state_d   = StIdle;
                irq_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            prev_q       <= 3'b000;
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            irq_req_q    <= 1'b0;
            irq_id_q     <= 2'd0;
            irq_entry_q  <= ENTRY0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            irq_entry_q  <= irq_entry_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_entry  = irq_entry_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule
